// File: rtl/cam_packetizer_param.sv
// Camera packetizer: frames camera lines (data packets) and status dumps (control packets) into
// {marker, payload} words with valid/ready handshake, a pixel skid buffer and drop accounting.
// Optional feature macro: PKT_SEQNUM_EN (header word 3 carries a wrapping 8-bit sequence number;
// when undefined that word is the constant 0x01 and no sequence register exists).
module cam_packetizer_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CTRL_LEN = 101,
  parameter int unsigned PAD_LEN  = 2,
  parameter int unsigned BUF_AW   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  input  logic              stop_i,
  input  logic [DATA_W-1:0] cam_data_i,
  input  logic              cam_pclk_en_i,
  input  logic              cam_href_i,
  input  logic              cam_vsync_i,
  input  logic [DATA_W-1:0] status_data_i,
  output logic [7:0]        status_addr_o,
  output logic [DATA_W:0]   out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [15:0]       drop_cnt_o,
  output logic              busy_o
);

  localparam int unsigned Depth = 2 ** BUF_AW;
  localparam logic [7:0] LastHdr  = 8'd5;
  localparam logic [7:0] LastCtrl = 8'(CTRL_LEN - 1);
  localparam logic [7:0] LastPad  = 8'(PAD_LEN - 1);

  typedef enum logic [2:0] {StIdle, StHdr, StType, StCtrl, StData, StTrail} state_e;

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       kind_q, kind_d;  // 1: data packet, 0: control packet

  // Capture pins pass through one register stage; pixels are delayed by the same stage so the
  // pixel that coincides with the href edge is still available when the edge is seen.
  logic vsync_q, vsync_qq, href_q, href_qq, stop_q, stop_qq, pclk_q;
  logic [DATA_W-1:0] pix_q;
  logic vsync_rise, href_rise, stop_rise, abort;

  logic [DATA_W-1:0] mem [Depth];
  logic [BUF_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [BUF_AW:0]   count_q;
  logic              empty, full, wr_req, wr_ok, rd, flush, drop;
  logic [15:0]       drop_cnt_q;
  logic [DATA_W-1:0] seq_word, hdr_word;

  assign vsync_rise = vsync_q & ~vsync_qq;
  assign href_rise  = href_q & ~href_qq;
  assign stop_rise  = stop_q & ~stop_qq;
  assign abort      = stop_rise & (state_q inside {StHdr, StType, StCtrl, StData});
  assign empty      = (count_q == '0);
  assign full       = (count_q == (BUF_AW + 1)'(Depth));
  assign wr_ok      = wr_req & (~full | rd);
  assign drop       = wr_req & full & ~rd;
  assign drop_cnt_o = drop_cnt_q;
  assign busy_o     = (state_q != StIdle);

`ifdef PKT_SEQNUM_EN
  logic [7:0] seq_q;
  assign seq_word = DATA_W'(seq_q);

  // Sequence number advances when the last trailer word is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seq_q <= 8'h00;
    end else if (state_q == StTrail && out_ready_i && cnt_q == LastPad) begin
      seq_q <= seq_q + 8'd1;
    end
  end
`else
  assign seq_word = DATA_W'(8'h01);
`endif

  // Header word selected by position within the header.
  always_comb begin
    hdr_word = DATA_W'(8'hAF);
    case (cnt_q)
      8'd0:    hdr_word = DATA_W'(8'h0D);
      8'd1:    hdr_word = DATA_W'(8'h0A);
      8'd2:    hdr_word = seq_word;
      8'd3:    hdr_word = DATA_W'(8'hCC);
      8'd4:    hdr_word = DATA_W'(8'hCC);
      default: hdr_word = DATA_W'(8'hAF);
    endcase
  end

  // Input stage registers for edge detection and pixel alignment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      href_q   <= 1'b0;
      href_qq  <= 1'b0;
      stop_q   <= 1'b0;
      stop_qq  <= 1'b0;
      pclk_q   <= 1'b0;
      pix_q    <= '0;
    end else begin
      vsync_q  <= cam_vsync_i;
      vsync_qq <= vsync_q;
      href_q   <= cam_href_i;
      href_qq  <= href_q;
      stop_q   <= stop_i;
      stop_qq  <= stop_q;
      pclk_q   <= cam_pclk_en_i;
      pix_q    <= cam_data_i;
    end
  end

  // FSM state and per-packet word counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      kind_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
    end
  end

  // Next state, output word and buffer control.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    kind_d        = kind_q;
    out_valid_o   = 1'b0;
    out_data_o    = '0;
    status_addr_o = 8'd0;
    wr_req        = 1'b0;
    rd            = 1'b0;
    flush         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go_i && vsync_rise) begin
          state_d = StHdr;
          kind_d  = 1'b0;
          cnt_d   = 8'd0;
        end else if (go_i && href_rise) begin
          state_d = StHdr;
          kind_d  = 1'b1;
          cnt_d   = 8'd0;
          wr_req  = pclk_q;  // first pixel of the line arrives with its edge
        end
      end
      StHdr: begin
        out_valid_o = 1'b1;
        out_data_o  = {1'b1, hdr_word};
        wr_req      = kind_q & pclk_q & href_q;
        if (out_ready_i) begin
          if (cnt_q == LastHdr) begin
            state_d = StType;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StType: begin
        out_valid_o = 1'b1;
        out_data_o  = {1'b1, (kind_q ? DATA_W'(8'hFF) : DATA_W'(8'h00))};
        wr_req      = kind_q & pclk_q & href_q;
        if (out_ready_i) begin
          state_d = kind_q ? StData : StCtrl;
          cnt_d   = 8'd0;
        end
      end
      StCtrl: begin
        out_valid_o   = 1'b1;
        status_addr_o = cnt_q;
        out_data_o    = {1'b1, status_data_i};
        if (out_ready_i) begin
          if (cnt_q == LastCtrl) begin
            state_d = StTrail;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StData: begin
        out_valid_o = ~empty;
        out_data_o  = {1'b1, mem[rd_ptr_q]};
        wr_req      = pclk_q & href_q;
        rd          = ~empty & out_ready_i;
        if (!href_q && empty) begin
          state_d = StTrail;
          cnt_d   = 8'd0;
        end
      end
      StTrail: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          if (cnt_q == LastPad) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort withdraws the pending word, empties the buffer and jumps straight to the trailer.
    if (abort) begin
      out_valid_o = 1'b0;
      wr_req      = 1'b0;
      rd          = 1'b0;
      flush       = 1'b1;
      state_d     = StTrail;
      cnt_d       = 8'd0;
    end
  end

  // Pixel FIFO pointers and occupancy; a write into a full buffer succeeds only alongside a read.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd)    rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_ok, rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Pixel storage.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_ptr_q] <= pix_q;
  end

  // Saturating count of pixels discarded on overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= 16'd0;
    end else if (drop && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_cam_packetizer_param.sv
// Self-checking bench for cam_packetizer_param: randomized lines and status contents, expected
// packets built from the framing rules and compared word by word.
module tb_cam_packetizer_param;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned CTRL_LEN = 101;
  localparam int unsigned PAD_LEN  = 2;
  localparam int unsigned BUF_AW   = 4;
  localparam int unsigned HDR_LEN  = 7;  // six header words plus type word

  typedef logic [DATA_W:0] word_t;

  logic              clk = 1'b0;
  logic              rst, go, stop, pclk_en, href, vsync, out_ready;
  logic [DATA_W-1:0] cam_data, status_data;
  logic [7:0]        status_addr;
  logic [DATA_W:0]   out_data;
  logic              out_valid, busy;
  logic [15:0]       drop_cnt;

  logic [DATA_W-1:0] status_mem [256];
  word_t             got[$];
  logic [7:0]        got_addr[$];
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  assign status_data = status_mem[status_addr];

  cam_packetizer_param #(
    .DATA_W  (DATA_W),
    .CTRL_LEN(CTRL_LEN),
    .PAD_LEN (PAD_LEN),
    .BUF_AW  (BUF_AW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .go_i         (go),
    .stop_i       (stop),
    .cam_data_i   (cam_data),
    .cam_pclk_en_i(pclk_en),
    .cam_href_i   (href),
    .cam_vsync_i  (vsync),
    .status_data_i(status_data),
    .status_addr_o(status_addr),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .drop_cnt_o   (drop_cnt),
    .busy_o       (busy)
  );

  // Record every word that will transfer at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got.push_back(out_data);
      got_addr.push_back(status_addr);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; go = 1'b1; stop = 1'b0; pclk_en = 1'b0; href = 1'b0; vsync = 1'b0;
    cam_data = '0; out_ready = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    got.delete();
    got_addr.delete();
    cyc();
  endtask

  // Waits for a packet to start (bounded) and then to finish (bounded).
  task automatic wait_done(input int budget);
    int n = 0;
    while (!busy && n < 20) begin cyc(); n++; end
    while (busy && n < budget) begin cyc(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_done: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Reference packet: header, type, payload words with marker 1, then zero trailer words.
  task automatic build_pkt(input bit is_data, input int seq, input logic [DATA_W-1:0] pay[$],
                           output word_t pkt[$]);
    logic [DATA_W-1:0] seqw;
`ifdef PKT_SEQNUM_EN
    seqw = DATA_W'(seq % 256);
`else
    seqw = DATA_W'(1);
`endif
    pkt = {};
    pkt.push_back({1'b1, 8'h0D});
    pkt.push_back({1'b1, 8'h0A});
    pkt.push_back({1'b1, seqw});
    pkt.push_back({1'b1, 8'hCC});
    pkt.push_back({1'b1, 8'hCC});
    pkt.push_back({1'b1, 8'hAF});
    pkt.push_back(is_data ? {1'b1, 8'hFF} : {1'b1, 8'h00});
    foreach (pay[i]) pkt.push_back({1'b1, pay[i]});
    for (int i = 0; i < int'(PAD_LEN); i++) pkt.push_back('0);
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b1; stop = 1'b0; pclk_en = 1'b0; href = 1'b0; vsync = 1'b0;
    cam_data = '0; out_ready = 1'b1;
    repeat (2) cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++; if (status_addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", status_addr); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    repeat (5) cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_ctrl();
    logic [DATA_W-1:0] pay[$];
    word_t exp[$];
    do_reset();
    for (int i = 0; i < int'(CTRL_LEN); i++) pay.push_back(status_mem[i]);
    build_pkt(1'b0, 0, pay, exp);
    vsync = 1'b1;
    repeat (3) cyc();
    vsync = 1'b0;
    go = 1'b0;  // dropping go mid-packet must not disturb the packet
    wait_done(400);
    go = 1'b1;
    checks++;
    if (got.size() !== exp.size()) begin
      errors++; $display("FAIL ctrl_len: got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL ctrl_word[%0d]: got %h want %h", i, got[i], exp[i]); end
    end
    for (int i = 0; i < int'(CTRL_LEN) && HDR_LEN + i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[HDR_LEN+i] !== 8'(i)) begin
        errors++; $display("FAIL ctrl_addr[%0d]: got %0d want %0d", i, got_addr[HDR_LEN+i], i);
      end
    end
  endtask

  task automatic test_data();
    logic [DATA_W-1:0] pay[$];
    word_t exp[$];
    int n;
    for (int rep = 0; rep < 3; rep++) begin
      do_reset();
      pay = {};
      n = $urandom_range(5, 20);
      href = 1'b1;
      while (pay.size() < n) begin
        pclk_en = ($urandom_range(0, 3) != 0);
        cam_data = DATA_W'($urandom);
        if (pclk_en) pay.push_back(cam_data);
        cyc();
      end
      href = 1'b0; pclk_en = 1'b0;
      build_pkt(1'b1, 0, pay, exp);
      wait_done(300);
      checks++;
      if (got.size() !== exp.size()) begin
        errors++; $display("FAIL data_len: got %0d want %0d", got.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin errors++; $display("FAIL data_word[%0d]: got %h want %h", i, got[i], exp[i]); end
      end
      checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL data_drop: got %0d want 0", drop_cnt); end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] pix[$];
    logic [DATA_W-1:0] pay[$];
    word_t exp[$];
    word_t held;
    bit have = 1'b0;
    int n;
    do_reset();
    n = $urandom_range(17, 24);
    for (int i = 0; i < n; i++) pix.push_back(DATA_W'($urandom));
    for (int i = 0; i < (1 << BUF_AW); i++) pay.push_back(pix[i]);
    out_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      href = (i < n); pclk_en = (i < n); cam_data = (i < n) ? pix[i] : '0;
      cyc();
      if (out_valid) begin
        if (!have) begin
          held = out_data; have = 1'b1;
          checks++;
          if (held !== {1'b1, 8'h0D}) begin errors++; $display("FAIL bp_first: got %h want 10d", held); end
        end else begin
          checks++;
          if (out_data !== held) begin errors++; $display("FAIL bp_stable: got %h want %h", out_data, held); end
        end
      end
    end
    href = 1'b0; pclk_en = 1'b0;
    checks++; if (!have) begin errors++; $display("FAIL bp_valid: got no valid word want one"); end
    out_ready = 1'b1;
    build_pkt(1'b1, 0, pay, exp);
    wait_done(300);
    checks++;
    if (got.size() !== exp.size()) begin
      errors++; $display("FAIL bp_len: got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL bp_word[%0d]: got %h want %h", i, got[i], exp[i]); end
    end
    checks++;
    if (drop_cnt !== 16'(n - (1 << BUF_AW))) begin
      errors++; $display("FAIL bp_drop: got %0d want %0d", drop_cnt, n - (1 << BUF_AW));
    end
  endtask

  task automatic test_stop();
    logic [DATA_W-1:0] pay[$];
    word_t exp[$];
    int k, n;
    do_reset();
    vsync = 1'b1; cyc(); vsync = 1'b0;
    n = 0;
    while (got.size() < HDR_LEN + 51 && n < 300) begin cyc(); n++; end
    stop = 1'b1;
    wait_done(300);
    stop = 1'b0;
    // Accepted control words must be an in-order prefix ending near word 50, then the trailer.
    k = got.size() - HDR_LEN - PAD_LEN;
    checks++;
    if (k < 51 || k > 53) begin errors++; $display("FAIL stop_words: got %0d ctrl words want 51..53", k); end
    for (int i = 0; i < k && i < int'(CTRL_LEN); i++) pay.push_back(status_mem[i]);
    build_pkt(1'b0, 0, pay, exp);
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL stop_word[%0d]: got %h want %h", i, got[i], exp[i]); end
    end
    got.delete(); got_addr.delete();
    pay = {};
    for (int i = 0; i < int'(CTRL_LEN); i++) pay.push_back(status_mem[i]);
    build_pkt(1'b0, 1, pay, exp);
    vsync = 1'b1; cyc(); vsync = 1'b0;
    wait_done(400);
    checks++;
    if (got.size() !== exp.size()) begin
      errors++; $display("FAIL stop_next_len: got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL stop_next[%0d]: got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_vsync_href();
    logic [DATA_W-1:0] pay[$];
    word_t exp[$];
    do_reset();
    vsync = 1'b1; href = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pclk_en = 1'b1; cam_data = DATA_W'($urandom);
      cyc();
    end
    vsync = 1'b0; href = 1'b0; pclk_en = 1'b0;
    for (int i = 0; i < int'(CTRL_LEN); i++) pay.push_back(status_mem[i]);
    build_pkt(1'b0, 0, pay, exp);
    wait_done(400);
    repeat (20) cyc();
    checks++;
    if (got.size() !== exp.size()) begin
      errors++; $display("FAIL vh_len: got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL vh_word[%0d]: got %h want %h", i, got[i], exp[i]); end
    end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL vh_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      href = (i < 20); pclk_en = (i < 20); cam_data = DATA_W'($urandom);
      cyc();
    end
    href = 1'b0; pclk_en = 1'b0;
    checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL rm_drop_pre: got %0d want 4", drop_cnt); end
    out_ready = 1'b1;
    repeat (10) cyc();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_pre: got %b want 1", busy); end
    rst = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", out_valid); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rm_drop: got %0d want 0", drop_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
    rst = 1'b0;
    got.delete(); got_addr.delete();
    repeat (30) cyc();
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL rm_no_trailer: got %0d words want 0", got.size()); end
  endtask

  task automatic test_seq_wrap();
    logic [DATA_W-1:0] pay[$];
    word_t exp[$];
    do_reset();
    for (int p = 0; p <= 256; p++) begin
      pay = {DATA_W'(p)};
      build_pkt(1'b1, p, pay, exp);
      href = 1'b1; pclk_en = 1'b1; cam_data = DATA_W'(p);
      cyc();
      href = 1'b0; pclk_en = 1'b0;
      wait_done(100);
      checks++;
      if (got.size() !== exp.size()) begin
        errors++; $display("FAIL seq_len[%0d]: got %0d want %0d", p, got.size(), exp.size());
      end else begin
        checks++;
        if (got[2] !== exp[2]) begin errors++; $display("FAIL seq_word[%0d]: got %h want %h", p, got[2], exp[2]); end
        checks++;
        if (got[HDR_LEN] !== exp[HDR_LEN]) begin
          errors++; $display("FAIL seq_pix[%0d]: got %h want %h", p, got[HDR_LEN], exp[HDR_LEN]);
        end
      end
      got.delete(); got_addr.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) status_mem[i] = DATA_W'($urandom);
    test_reset();
    test_ctrl();
    test_data();
    test_backpressure();
    test_stop();
    test_vsync_href();
    test_rst_mid();
    test_seq_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
